// File: rtl/db_luma_sched_pkg.sv
// Shared types and constants for the luma deblocking edge scheduler.
// Optional feature macro: DB_SKIP_ZERO_BS_EN.
package db_luma_sched_pkg;

   localparam int LINES_PER_EDGE = 16;
   localparam int EDGES          = 4;
   localparam int PIPE_LAT       = 2;
   localparam int BUF_LAT        = 1;
   localparam int DRAIN_CYC      = 3;
   localparam int BS_W           = 3;
   localparam int SEGS           = 4;
   localparam int EDGE_BITS      = SEGS * BS_W;
   localparam int BS_BITS        = EDGES * EDGE_BITS;
   localparam int WR_DLY         = BUF_LAT + PIPE_LAT;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_VER     = 3'd1;
   localparam logic [2:0] ST_DRAIN_V = 3'd2;
   localparam logic [2:0] ST_HOR     = 3'd3;
   localparam logic [2:0] ST_DRAIN_H = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;

   typedef struct packed {
      logic       en;
      logic       dir;
      logic [1:0] edg;
      logic [3:0] line;
   } line_addr_t;

   // First edge >= from that must be issued; 4 means none remain.
   function automatic logic [2:0] seek_edge(
      input logic [BS_BITS-1:0] bs,
      input logic [2:0]         from,
      input logic               skip
   );
      logic [2:0] r;
      r = 3'd4;
      for (int e = EDGES - 1; e >= 0; e--) begin
         if (3'(e) >= from &&
             (!skip || (|bs[e*EDGE_BITS +: EDGE_BITS])))
            r = 3'(e);
      end
      return r;
   endfunction

endpackage

// File: rtl/db_luma_sched_if.sv
// Control/data bundle between the MB controller and the luma scheduler.
// Feature macro DB_SKIP_ZERO_BS_EN does not change this bundle.
interface db_luma_sched_if;

   logic        start_i;
   logic [5:0]  qp_cur_i;
   logic [5:0]  qp_left_i;
   logic [5:0]  qp_top_i;
   logic [47:0] bs_ver_i;
   logic [47:0] bs_hor_i;

   logic        busy_o;
   logic        done_o;
   logic        rd_en_o;
   logic        rd_dir_o;
   logic [1:0]  rd_edge_o;
   logic [3:0]  rd_line_o;
   logic [2:0]  pipe_bs_o;
   logic [5:0]  pipe_qp1_o;
   logic [5:0]  pipe_qp2_o;
   logic        wr_en_o;
   logic        wr_dir_o;
   logic [1:0]  wr_edge_o;
   logic [3:0]  wr_line_o;

   modport master (
      output start_i, qp_cur_i, qp_left_i, qp_top_i,
      output bs_ver_i, bs_hor_i,
      input  busy_o, done_o,
      input  rd_en_o, rd_dir_o, rd_edge_o, rd_line_o,
      input  pipe_bs_o, pipe_qp1_o, pipe_qp2_o,
      input  wr_en_o, wr_dir_o, wr_edge_o, wr_line_o
   );

   modport slave (
      input  start_i, qp_cur_i, qp_left_i, qp_top_i,
      input  bs_ver_i, bs_hor_i,
      output busy_o, done_o,
      output rd_en_o, rd_dir_o, rd_edge_o, rd_line_o,
      output pipe_bs_o, pipe_qp1_o, pipe_qp2_o,
      output wr_en_o, wr_dir_o, wr_edge_o, wr_line_o
   );

endinterface

// File: rtl/db_sched_dly.sv
// Parameterised-depth shift register, async active-low reset.
// Feature macro DB_SKIP_ZERO_BS_EN does not affect this block.
module db_sched_dly #(
   parameter int W     = 8,
   parameter int DEPTH = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [DEPTH-1:0][W-1:0] sr_q;
   logic [DEPTH-1:0][W-1:0] sr_d;

   always_comb begin
      sr_d    = sr_q;
      sr_d[0] = d_i;
      for (int i = 1; i < DEPTH; i++)
         sr_d[i] = sr_q[i-1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sr_q <= '0;
      else      sr_q <= sr_d;
   end

   assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/db_luma_sched.sv
// Luma deblocking edge scheduler: issues line reads, pipeline bS/QP, writes.
// Define DB_SKIP_ZERO_BS_EN to skip edges whose four bS segments are 0.
module db_luma_sched
   import db_luma_sched_pkg::*;
(
   input logic            clk,
   input logic            rst,
   db_luma_sched_if.slave bus
);

`ifdef DB_SKIP_ZERO_BS_EN
   localparam logic SKIP_EN = 1'b1;
`else
   localparam logic SKIP_EN = 1'b0;
`endif

   logic [2:0]         state_q, state_d;
   logic [5:0]         cnt_q, cnt_d;
   logic [BS_BITS-1:0] bs_ver_q, bs_ver_d;
   logic [BS_BITS-1:0] bs_hor_q, bs_hor_d;
   logic [5:0]         qp_cur_q, qp_cur_d;
   logic [5:0]         qp_left_q, qp_left_d;
   logic [5:0]         qp_top_q, qp_top_d;
   logic [2:0]         pipe_bs_q, pipe_bs_d;
   logic [5:0]         pipe_qp1_q, pipe_qp1_d;
   logic [5:0]         pipe_qp2_q, pipe_qp2_d;

   logic [2:0]         nxt_e;
   line_addr_t         rd_a;
   line_addr_t         wr_a;
   logic [BS_BITS-1:0] bs_dir;
   logic [3:0]         seg_idx;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bs_ver_d  = bs_ver_q;
      bs_hor_d  = bs_hor_q;
      qp_cur_d  = qp_cur_q;
      qp_left_d = qp_left_q;
      qp_top_d  = qp_top_q;
      nxt_e     = 3'd0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start_i) begin
               bs_ver_d  = bus.bs_ver_i;
               bs_hor_d  = bus.bs_hor_i;
               qp_cur_d  = bus.qp_cur_i;
               qp_left_d = bus.qp_left_i;
               qp_top_d  = bus.qp_top_i;
               nxt_e     = seek_edge(bus.bs_ver_i, 3'd0, SKIP_EN);
               state_d   = nxt_e[2] ? ST_DRAIN_V : ST_VER;
               cnt_d     = {nxt_e[1:0], 4'd0};
            end
         end
         ST_VER: begin
            if (cnt_q[3:0] == 4'hF) begin
               nxt_e   = seek_edge(bs_ver_q,
                                   {1'b0, cnt_q[5:4]} + 3'd1,
                                   SKIP_EN);
               state_d = nxt_e[2] ? ST_DRAIN_V : ST_VER;
               cnt_d   = {nxt_e[1:0], 4'd0};
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         ST_DRAIN_V: begin
            if (cnt_q == 6'(DRAIN_CYC - 1)) begin
               nxt_e   = seek_edge(bs_hor_q, 3'd0, SKIP_EN);
               state_d = nxt_e[2] ? ST_DRAIN_H : ST_HOR;
               cnt_d   = {nxt_e[1:0], 4'd0};
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         ST_HOR: begin
            if (cnt_q[3:0] == 4'hF) begin
               nxt_e   = seek_edge(bs_hor_q,
                                   {1'b0, cnt_q[5:4]} + 3'd1,
                                   SKIP_EN);
               state_d = nxt_e[2] ? ST_DRAIN_H : ST_HOR;
               cnt_d   = {nxt_e[1:0], 4'd0};
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         ST_DRAIN_H: begin
            if (cnt_q == 6'(DRAIN_CYC - 1)) begin
               state_d = ST_DONE;
               cnt_d   = 6'd0;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = 6'd0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 6'd0;
         end
      endcase
   end

   // Read address is zeroed outside VER/HOR so idle buses stay at 0.
   always_comb begin
      rd_a.en   = (state_q == ST_VER) || (state_q == ST_HOR);
      rd_a.dir  = rd_a.en && (state_q == ST_HOR);
      rd_a.edg  = rd_a.en ? cnt_q[5:4] : 2'd0;
      rd_a.line = rd_a.en ? cnt_q[3:0] : 4'd0;
   end

   always_comb begin
      bs_dir     = rd_a.dir ? bs_hor_q : bs_ver_q;
      seg_idx    = {rd_a.edg, rd_a.line[3:2]};
      pipe_bs_d  = 3'd0;
      pipe_qp1_d = 6'd0;
      pipe_qp2_d = 6'd0;
      if (rd_a.en) begin
         pipe_bs_d  = bs_dir[seg_idx*BS_W +: BS_W];
         pipe_qp2_d = qp_cur_q;
         if (rd_a.edg == 2'd0)
            pipe_qp1_d = rd_a.dir ? qp_top_q : qp_left_q;
         else
            pipe_qp1_d = qp_cur_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bs_ver_q   <= '0;
         bs_hor_q   <= '0;
         qp_cur_q   <= '0;
         qp_left_q  <= '0;
         qp_top_q   <= '0;
         pipe_bs_q  <= '0;
         pipe_qp1_q <= '0;
         pipe_qp2_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bs_ver_q   <= bs_ver_d;
         bs_hor_q   <= bs_hor_d;
         qp_cur_q   <= qp_cur_d;
         qp_left_q  <= qp_left_d;
         qp_top_q   <= qp_top_d;
         pipe_bs_q  <= pipe_bs_d;
         pipe_qp1_q <= pipe_qp1_d;
         pipe_qp2_q <= pipe_qp2_d;
      end
   end

   db_sched_dly #(
      .W     ($bits(line_addr_t)),
      .DEPTH (WR_DLY)
   ) u_wr_dly (
      .clk (clk),
      .rst (rst),
      .d_i (rd_a),
      .q_o (wr_a)
   );

   assign bus.busy_o     = (state_q != ST_IDLE);
   assign bus.done_o     = (state_q == ST_DONE);
   assign bus.rd_en_o    = rd_a.en;
   assign bus.rd_dir_o   = rd_a.dir;
   assign bus.rd_edge_o  = rd_a.edg;
   assign bus.rd_line_o  = rd_a.line;
   assign bus.pipe_bs_o  = pipe_bs_q;
   assign bus.pipe_qp1_o = pipe_qp1_q;
   assign bus.pipe_qp2_o = pipe_qp2_q;
   assign bus.wr_en_o    = wr_a.en;
   assign bus.wr_dir_o   = wr_a.dir;
   assign bus.wr_edge_o  = wr_a.edg;
   assign bus.wr_line_o  = wr_a.line;

endmodule

// File: tb/tb_db_luma_sched.sv
// Bench for db_luma_sched: per-cycle schedule model plus literal checks.
// Honours DB_SKIP_ZERO_BS_EN when the build defines it.
module tb_db_luma_sched;

   localparam int MAXC = 1024;
   localparam int T1 = 5;
   localparam int T2 = T1 + 140;
   localparam int T3 = T2 + 140;
   localparam int T4 = T3 + 220;

`ifdef DB_SKIP_ZERO_BS_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       rd_en;
      logic       rd_dir;
      logic [1:0] rd_edge;
      logic [3:0] rd_line;
      logic [2:0] pbs;
      logic [5:0] q1;
      logic [5:0] q2;
      logic       wr_en;
      logic       wr_dir;
      logic [1:0] wr_edge;
      logic [3:0] wr_line;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   db_luma_sched_if bus();

   db_luma_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   int   m_end = -1;
   obs_t exp_q [MAXC];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [2:0] seg_bs(
      input logic [47:0] bs, input int e, input int l);
      return bs[(e*4 + l/4)*3 +: 3];
   endfunction

   function automatic logic [47:0] bs_all(input logic [2:0] v);
      logic [47:0] r;
      for (int i = 0; i < 16; i++) r[i*3 +: 3] = v;
      return r;
   endfunction

   // Lay out the whole MB schedule from the start cycle onward.
   task automatic model_accept(input int s);
      int          t;
      logic [47:0] bs;
      logic [5:0]  q1;
      t = s + 1;
      for (int d = 0; d < 2; d++) begin
         bs = (d == 1) ? bus.bs_hor_i : bus.bs_ver_i;
         for (int e = 0; e < 4; e++) begin
            if (SKIP && bs[e*12 +: 12] == 12'd0) continue;
            for (int l = 0; l < 16; l++) begin
               if (e == 0) q1 = (d == 1) ? bus.qp_top_i : bus.qp_left_i;
               else        q1 = bus.qp_cur_i;
               if (t + 3 < MAXC) begin
                  exp_q[t].rd_en     = 1'b1;
                  exp_q[t].rd_dir    = 1'(d);
                  exp_q[t].rd_edge   = 2'(e);
                  exp_q[t].rd_line   = 4'(l);
                  exp_q[t+1].pbs     = seg_bs(bs, e, l);
                  exp_q[t+1].q1      = q1;
                  exp_q[t+1].q2      = bus.qp_cur_i;
                  exp_q[t+3].wr_en   = 1'b1;
                  exp_q[t+3].wr_dir  = 1'(d);
                  exp_q[t+3].wr_edge = 2'(e);
                  exp_q[t+3].wr_line = 4'(l);
               end
               t++;
            end
         end
         t += 3;
      end
      for (int c = s + 1; c <= t && c < MAXC; c++) exp_q[c].busy = 1'b1;
      if (t < MAXC) exp_q[t].done = 1'b1;
      m_end = t;
   endtask

   always @(posedge clk) begin
      if (rst && bus.start_i && cyc > m_end) model_accept(cyc);
   end

   always @(negedge rst) begin
      for (int c = cyc; c < MAXC; c++) exp_q[c] = '0;
      m_end = -1;
   end

   always @(negedge clk) begin
      obs_t a;
      if (bus.done_o) done_cnt++;
      if (cyc < MAXC) begin
         a.busy    = bus.busy_o;
         a.done    = bus.done_o;
         a.rd_en   = bus.rd_en_o;
         a.rd_dir  = bus.rd_dir_o;
         a.rd_edge = bus.rd_edge_o;
         a.rd_line = bus.rd_line_o;
         a.pbs     = bus.pipe_bs_o;
         a.q1      = bus.pipe_qp1_o;
         a.q2      = bus.pipe_qp2_o;
         a.wr_en   = bus.wr_en_o;
         a.wr_dir  = bus.wr_dir_o;
         a.wr_edge = bus.wr_edge_o;
         a.wr_line = bus.wr_line_o;
         checks++;
         if (a !== exp_q[cyc]) begin
            errors++;
            if (errors <= 20)
               $display("FAIL model cycle %0d: got %h expected %h",
                        cyc, a, exp_q[cyc]);
         end
      end
   end

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic drive_at(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_neg(input int n);
      do @(negedge clk); while (cyc < n);
   endtask

   task automatic pulse_start(input int n);
      drive_at(n);
      bus.start_i = 1'b1;
      drive_at(n + 1);
      bus.start_i = 1'b0;
   endtask

   initial begin
      #(MAXC * 10 + 500);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] v;
      int          dn;
      bus.start_i   = 1'b0;
      bus.qp_cur_i  = 6'd30;
      bus.qp_left_i = 6'd20;
      bus.qp_top_i  = 6'd25;
      bus.bs_ver_i  = bs_all(3'd2);
      bus.bs_hor_i  = bs_all(3'd2);
      drive_at(2);
      rst = 1'b1;

      // Baseline MB
      wait_neg(3);
      chk("idle_busy", int'(bus.busy_o), 0);
      pulse_start(T1);
      wait_neg(T1 + 1);
      chk("t1_rd_first", int'(bus.rd_en_o), 1);
      wait_neg(T1 + 2);
      chk("t1_qp1", int'(bus.pipe_qp1_o), 20);
      chk("t1_qp2", int'(bus.pipe_qp2_o), 30);
      chk("t1_bs", int'(bus.pipe_bs_o), 2);
      wait_neg(T1 + 64);
      chk("t1_rd_64", int'(bus.rd_en_o), 1);
      wait_neg(T1 + 65);
      chk("t1_rd_65", int'(bus.rd_en_o), 0);
      wait_neg(T1 + 67);
      chk("t1_wr_67", int'({bus.wr_en_o, bus.wr_dir_o}), 2);
      wait_neg(T1 + 68);
      chk("t1_rd_68", int'({bus.rd_en_o, bus.rd_dir_o}), 3);
      wait_neg(T1 + 69);
      chk("t1_qp1_hor", int'(bus.pipe_qp1_o), 25);
      wait_neg(T1 + 135);
      chk("t1_done", int'(bus.done_o), 1);
      wait_neg(T1 + 136);
      chk("t1_busy_end", int'(bus.busy_o), 0);

      // Single hot bS segment, plus a start while busy
      v = bs_all(3'd1);
      v[35:33] = 3'd4;
      bus.bs_ver_i = v;
      bus.bs_hor_i = bs_all(3'd1);
      pulse_start(T2);
      pulse_start(T2 + 40);
      wait_neg(T2 + 45);
      chk("t2_bs_l11", int'(bus.pipe_bs_o), 1);
      wait_neg(T2 + 46);
      chk("t2_bs_l12", int'(bus.pipe_bs_o), 4);
      wait_neg(T2 + 49);
      chk("t2_bs_l15", int'(bus.pipe_bs_o), 4);
      wait_neg(T2 + 50);
      chk("t2_bs_e3", int'(bus.pipe_bs_o), 1);
      wait_neg(T2 + 138);
      chk("t2_done_cnt", done_cnt, 2);

      // Reset mid-MB
      pulse_start(T3);
      drive_at(T3 + 70);
      rst = 1'b0;
      wait_neg(T3 + 70);
      chk("t3_rst_busy", int'(bus.busy_o), 0);
      wait_neg(T3 + 71);
      chk("t3_rst_rd", int'(bus.rd_en_o), 0);
      chk("t3_rst_wr", int'(bus.wr_en_o), 0);
      drive_at(T3 + 72);
      rst = 1'b1;
      pulse_start(T3 + 75);
      wait_neg(T3 + 140);
      chk("t3_no_stale", done_cnt, 2);
      wait_neg(T3 + 210);
      chk("t3_done", int'(bus.done_o), 1);

      // Zero-bS vertical edges 1 and 3
      v = bs_all(3'd1);
      v[23:12] = 12'd0;
      v[47:36] = 12'd0;
      bus.bs_ver_i = v;
      bus.bs_hor_i = bs_all(3'd1);
      dn = SKIP ? 103 : 135;
      pulse_start(T4);
      wait_neg(T4 + 17);
      chk("t4_edge_2nd", int'(bus.rd_edge_o), SKIP ? 2 : 1);
      wait_neg(T4 + dn);
      chk("t4_done", int'(bus.done_o), 1);
      wait_neg(T4 + 150);
      chk("done_total", done_cnt, 4);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
